// File: rtl/proab_pkg.sv
// Shared definitions for the proab producer stage.
//   state_t   : FSM state encoding of proab_sum_calu (also exported on dbg_state)
//   FP_*      : IEEE-754 single-precision constants
//   fp_add_f  : single-precision add, round-to-nearest-even, denormals flushed
//               to zero, NaN/Inf propagated. Used by fp_add.
package proab_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_WAIT_ADD = 3'd2,
    ST_HOLD     = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam int          FP_W    = 32;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  function automatic logic [31:0] fp_add_f(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x;
    logic [31:0] y;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [26:0] mx;      // hidden bit + 23 fraction bits + guard/round/sticky
    logic [26:0] my;
    logic [27:0] ms;
    logic [24:0] mr;
    logic        sticky;
    logic        rnd;
    int          d;
    int          er;

    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    // A zero exponent field is a zero or a denormal; both are treated as zero.
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);

    if (a_nan || b_nan) return FP_QNAN;
    if (a_inf && b_inf) return (a[31] != b[31]) ? FP_QNAN : a;
    if (a_inf) return a;
    if (b_inf) return b;
    if (a_zero && b_zero) return {a[31] & b[31], 31'd0};
    if (a_zero) return b;
    if (b_zero) return a;

    // x carries the larger magnitude, so the subtract path never borrows.
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end

    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    er = int'(x[30:23]);
    d  = er - int'(y[30:23]);

    // Align the smaller operand; bits shifted out collapse into the sticky bit.
    if (d > 26) begin
      my = 27'd1;
    end else if (d > 0) begin
      sticky = |(my & ((27'd1 << d) - 27'd1));
      my     = (my >> d) | {26'd0, sticky};
    end

    if (x[31] == y[31]) begin
      ms = {1'b0, mx} + {1'b0, my};
      if (ms[27]) begin
        ms = {1'b0, ms[27:2], ms[1] | ms[0]};
        er = er + 1;
      end
    end else begin
      ms = {1'b0, mx} - {1'b0, my};
      if (ms == 28'd0) return FP_ZERO;   // exact cancellation gives +0
      for (int i = 0; i < 27; i++) begin
        if (!ms[26]) begin
          ms = ms << 1;
          er = er - 1;
        end
      end
    end

    if (er <= 0) return {x[31], 31'd0};

    // Round to nearest, ties to even.
    rnd = ms[2] & (ms[1] | ms[0] | ms[3]);
    mr  = {1'b0, ms[26:3]} + {24'd0, rnd};
    if (mr[24]) begin
      mr = mr >> 1;
      er = er + 1;
    end
    if (er >= 255) return {x[31], 8'hFF, 23'd0};
    return {x[31], er[7:0], mr[22:0]};
  endfunction

endpackage

// File: rtl/proab_sum_calu_fp_add.sv
// fp_add: single-precision adder with a fixed latency of ADD_DELAY cycles.
//   clk, rst : clock, synchronous active-high reset (clears in-flight valids)
//   a, b     : operands, sampled when in_vld is high
//   in_vld   : operands valid
//   res      : a + b, presented ADD_DELAY cycles after in_vld
//   out_vld  : res valid
// The add itself is evaluated in the first stage; the remaining stages only
// delay the result so the latency matches the vendor adder it stands in for.
module fp_add
  import proab_pkg::*;
#(
  parameter int ADD_DELAY = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  input  logic            in_vld,
  output logic [FP_W-1:0] res,
  output logic            out_vld
);

  logic [FP_W-1:0] res_pipe [ADD_DELAY];
  logic            vld_pipe [ADD_DELAY];

  always_ff @(posedge clk) begin
    res_pipe[0] <= fp_add_f(a, b);
    for (int i = 1; i < ADD_DELAY; i++) begin
      res_pipe[i] <= res_pipe[i-1];
    end
    if (rst) begin
      for (int i = 0; i < ADD_DELAY; i++) begin
        vld_pipe[i] <= 1'b0;
      end
    end else begin
      vld_pipe[0] <= in_vld;
      for (int i = 1; i < ADD_DELAY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

  assign res     = res_pipe[ADD_DELAY-1];
  assign out_vld = vld_pipe[ADD_DELAY-1];

endmodule

// File: rtl/proab_sum_calu.sv
// proab_sum_calu: producer stage in front of proab_calu. Accepts a frame of
// DATA_SIZE floats, writes them in order into the intermediate memory and
// accumulates their sum serially through fp_add. When the frame is complete
// and the consumer is ready, the sum is published and proab_sum_done pulses.
//   clk, rst          : clock, synchronous active-high reset
//   proab_sum_start   : frame start request (taken only while proab_sum_ready)
//   proab_sum_ready   : high in IDLE while downstream_ready is high
//   in_data/valid/ready : element stream
//   wr_data/addr/ena  : registered intermediate-memory write port
//   sum               : last completed frame sum, held until the next DONE
//   downstream_ready  : proab_calu ready, sampled only in IDLE and HOLD
//   proab_sum_done    : one-cycle pulse, drives proab_calu_start
//   dbg_state         : current FSM state
//
// Handshake: an element transfers on a rising edge where in_valid and
// in_ready are both high. in_ready depends only on state, never on in_valid;
// the producer must hold in_data stable while in_valid is high and not yet
// accepted.
module proab_sum_calu
  import proab_pkg::*;
#(
  parameter int AW        = 12,
  parameter int DW        = 32,
  parameter int DATA_SIZE = 128,
  parameter int ADD_DELAY = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          proab_sum_start,
  output logic          proab_sum_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] wr_data,
  output logic [AW-1:0] wr_addr,
  output logic          wr_ena,
  output logic [DW-1:0] sum,
  input  logic          downstream_ready,
  output logic          proab_sum_done,
  output state_t        dbg_state
);

  state_t        state;
  logic [DW-1:0] acc;
  logic [AW-1:0] cnt;
  logic [DW-1:0] add_res;
  logic          add_vld;
  logic          accept;

  assign proab_sum_ready = (state == ST_IDLE) && downstream_ready;
  assign in_ready        = (state == ST_LOAD);
  assign accept          = in_valid && in_ready;
  assign dbg_state       = state;

  // Only one add is ever in flight, so acc is always the up-to-date left
  // operand when the next element is accepted.
  fp_add #(
    .ADD_DELAY (ADD_DELAY)
  ) u_fp_add (
    .clk     (clk),
    .rst     (rst),
    .a       (acc),
    .b       (in_data),
    .in_vld  (accept),
    .res     (add_res),
    .out_vld (add_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      acc            <= FP_ZERO;
      cnt            <= '0;
      sum            <= FP_ZERO;
      wr_ena         <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      proab_sum_done <= 1'b0;
    end else begin
      wr_ena         <= 1'b0;
      proab_sum_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (proab_sum_start && proab_sum_ready) begin
            acc   <= FP_ZERO;
            cnt   <= '0;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            wr_ena  <= 1'b1;
            wr_addr <= cnt;
            wr_data <= in_data;
            state   <= ST_WAIT_ADD;
          end
        end
        ST_WAIT_ADD: begin
          if (add_vld) begin
            acc <= add_res;
            if (cnt == AW'(DATA_SIZE - 1)) begin
              state <= ST_HOLD;
            end else begin
              cnt   <= cnt + AW'(1);
              state <= ST_LOAD;
            end
          end
        end
        ST_HOLD: begin
          if (downstream_ready) begin
            sum            <= acc;
            proab_sum_done <= 1'b1;
            state          <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proab_sum_calu.sv
module tb_proab_sum_calu;
  import proab_pkg::*;

  localparam int AW        = 12;
  localparam int DW        = 32;
  localparam int DATA_SIZE = 128;
  localparam int ADD_DELAY = 7;
  localparam int W         = AW + DW;
  localparam int FRAME_LAT = 1 + DATA_SIZE * (ADD_DELAY + 1) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          proab_sum_start = 1'b0;
  logic          proab_sum_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] wr_addr;
  logic          wr_ena;
  logic [DW-1:0] sum;
  logic          downstream_ready = 1'b1;
  logic          proab_sum_done;
  state_t        dbg_state;

  logic [W-1:0]  exp_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            done_cnt = 0;
  logic [DW-1:0] cur_sum = '0;

  proab_sum_calu #(
    .AW(AW), .DW(DW), .DATA_SIZE(DATA_SIZE), .ADD_DELAY(ADD_DELAY)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .proab_sum_start  (proab_sum_start),
    .proab_sum_ready  (proab_sum_ready),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .wr_data          (wr_data),
    .wr_addr          (wr_addr),
    .wr_ena           (wr_ena),
    .sum              (sum),
    .downstream_ready (downstream_ready),
    .proab_sum_done   (proab_sum_done),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Exact for the dyadic values used here (integers below 2^24, halves, twos).
  function automatic logic [31:0] real_to_fp(input real v);
    real         m;
    int          e;
    logic        s;
    logic [22:0] f;
    if (v == 0.0) return 32'h0;
    s = (v < 0.0);
    m = s ? -v : v;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    f = 23'($rtoi((m - 1.0) * 8388608.0));
    return {s, 8'(127 + e), f};
  endfunction

  // ---------------- scoreboard: memory writes and done pulses ----------------
  always @(negedge clk) begin
    logic [W-1:0] item;
    if (wr_ena) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 32'(wr_ena), 32'd0);
      end else begin
        item = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(item[W-1:DW]));
        check("wr_data", wr_data, item[DW-1:0]);
      end
    end
    if (proab_sum_done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic reset_and_check(input string tag);
    in_valid         = 1'b0;
    proab_sum_start  = 1'b0;
    downstream_ready = 1'b1;
    rst              = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check({tag, "_state"},    32'(dbg_state), 32'(ST_IDLE));
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_wr_ena"},   32'(wr_ena), 32'd0);
    check({tag, "_wr_addr"},  32'(wr_addr), 32'd0);
    check({tag, "_wr_data"},  wr_data, 32'd0);
    check({tag, "_done"},     32'(proab_sum_done), 32'd0);
    check({tag, "_sum"},      sum, 32'd0);
    check({tag, "_ready"},    32'(proab_sum_ready), 32'd1);
    exp_q.delete();
    cur_sum = '0;
    repeat (12) begin
      @(posedge clk); #1;
      check({tag, "_idle"}, 32'(dbg_state), 32'(ST_IDLE));
    end
  endtask

  // kind: 0 = ones, 1 = halves, 2 = twos, 3 = random integers in [-1000,1000]
  task automatic run_frame(input int kind, input int pct, input int ds_low_at,
                           input int start_mid_at, input int rst_at);
    logic [31:0] elems [DATA_SIZE];
    real         v;
    real         tot;
    int          idx;
    int          budget;
    int          start_cyc;
    int          rise_cyc;
    int          dc0;
    bit          acc_now;

    tot = 0.0;
    for (int i = 0; i < DATA_SIZE; i++) begin
      case (kind)
        0:       v = 1.0;
        1:       v = 0.5;
        2:       v = 2.0;
        default: v = real'(int'($urandom_range(2000)) - 1000);
      endcase
      elems[i] = real_to_fp(v);
      tot      = tot + v;
    end

    dc0              = done_cnt;
    downstream_ready = 1'b1;
    proab_sum_start  = 1'b1;
    start_cyc        = cyc;
    check("start_ready", 32'(proab_sum_ready), 32'd1);
    @(posedge clk); #1;
    proab_sum_start = 1'b0;

    idx    = 0;
    budget = 0;
    rise_cyc = 0;
    while (idx < DATA_SIZE && budget < 4000) begin
      in_valid        = (int'($urandom_range(99)) < pct);
      in_data         = elems[idx];
      proab_sum_start = (idx == start_mid_at);
      if (ds_low_at >= 0 && idx >= ds_low_at) downstream_ready = 1'b0;
      #1;
      check("busy_ready", 32'(proab_sum_ready), 32'd0);
      acc_now = in_valid && in_ready;
      if (acc_now) exp_q.push_back({AW'(idx), elems[idx]});
      @(posedge clk); #1;
      budget++;
      if (acc_now) begin
        idx++;
        check("sum_hold", sum, cur_sum);
        if (idx == rst_at) begin
          reset_and_check("rst_mid");
          return;
        end
      end
    end
    check("accept_count", 32'(idx), 32'(DATA_SIZE));
    in_valid        = 1'b0;
    proab_sum_start = 1'b0;

    if (ds_low_at >= 0) begin
      repeat (ADD_DELAY + 50) begin
        @(posedge clk); #1;
        check("done_early", 32'(proab_sum_done), 32'd0);
      end
      check("sum_prev", sum, cur_sum);
      downstream_ready = 1'b1;
      rise_cyc         = cyc;
    end

    budget = 0;
    while (!proab_sum_done && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    check("done_seen", 32'(proab_sum_done), 32'd1);
    if (pct >= 100 && ds_low_at < 0) check("done_lat", 32'(cyc - start_cyc), 32'(FRAME_LAT));
    if (ds_low_at >= 0) check("done_after_rise", 32'(cyc - rise_cyc), 32'd1);
    cur_sum = real_to_fp(tot);
    check("sum", sum, cur_sum);

    @(posedge clk); #1;
    check("done_pulse", 32'(proab_sum_done), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("sum_stable", sum, cur_sum);
    end
    check("done_count", 32'(done_cnt - dc0), 32'd1);
    check("writes_left", 32'(exp_q.size()), 32'd0);
    check("end_state", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic idle_start_ignored();
    downstream_ready = 1'b0;
    in_valid         = 1'b1;
    in_data          = 32'h3F80_0000;
    proab_sum_start  = 1'b1;
    #1;
    check("idle_ready_lo", 32'(proab_sum_ready), 32'd0);
    @(posedge clk); #1;
    proab_sum_start = 1'b0;
    repeat (6) begin
      check("idle_state", 32'(dbg_state), 32'(ST_IDLE));
      check("idle_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid         = 1'b0;
    downstream_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_and_check("por");

    run_frame(0, 100, -1, -1, -1);          // full rate ones
    check("sum_ones", sum, 32'h4300_0000);
    run_frame(0, 100, 120, -1, -1);         // consumer stalls the hand-off
    run_frame(0, 50, -1, 10, -1);           // gappy stream, start during LOAD
    idle_start_ignored();
    run_frame(0, 100, -1, -1, 40);          // reset after element 40
    run_frame(1, 100, -1, -1, -1);          // halves
    check("sum_halves", sum, 32'h4280_0000);
    run_frame(0, 100, -1, -1, -1);          // back-to-back ones then twos
    run_frame(2, 100, -1, -1, -1);
    check("sum_twos", sum, 32'h4380_0000);
    for (int f = 0; f < 3; f++) begin
      run_frame(3, int'($urandom_range(100, 30)), -1, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/proab_sum_calu.md
# proab_sum_calu

Producer stage in front of `proab_calu`. It accepts a frame of DATA_SIZE single-precision values on a valid/ready stream and writes them in order into the intermediate memory that `proab_calu` reads. While writing, it accumulates their floating-point sum. When the frame is complete and the consumer is ready, it presents the sum and pulses `proab_sum_done`, which drives `proab_calu_start`.

## Interface
- AW, 12, address width of the intermediate-memory write port; must satisfy 2^AW >= DATA_SIZE
- DW, 32, data width; IEEE-754 single precision
- DATA_SIZE, 128, elements per frame
- ADD_DELAY, 7, fixed pipeline latency of the `fp_add` sub-module in cycles; must be >= 1
- clk  input  1  sole clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- proab_sum_start  input  1  one-cycle frame start request from the upstream process
- proab_sum_ready  output  1  high when a start request will be accepted
- in_data  input  DW  stream element
- in_valid  input  1  `in_data` is valid
- in_ready  output  1  block accepts `in_data` this cycle
- wr_data  output  DW  intermediate-memory write data
- wr_addr  output  AW  intermediate-memory write address
- wr_ena  output  1  intermediate-memory write enable
- sum  output  DW  frame sum sent to `proab_calu`
- downstream_ready  input  1  connected to `proab_calu_ready`
- proab_sum_done  output  1  one-cycle pulse; connected to `proab_calu_start`

## Operation
- States: IDLE, LOAD, WAIT_ADD, HOLD, DONE.
- **IDLE**
  - `proab_sum_ready = downstream_ready`.
  - `proab_sum_start` while `proab_sum_ready` is high: clear accumulator `acc` to 0 and element counter `cnt` to 0, then go to LOAD.
  - Start requests at any other time or in any other state are ignored.
- **LOAD**
  - `in_ready` = 1.
  - On `in_valid & in_ready`:
    - register a write of `in_data` to address `cnt`;
    - issue `fp_add(acc, in_data)`;
    - go to WAIT_ADD.
- **WAIT_ADD**
  - `in_ready` = 0.
  - When the `fp_add` result is valid, load it into `acc`.
  - If `cnt == DATA_SIZE-1`, go to HOLD; otherwise increment `cnt` and go to LOAD.
- **HOLD**
  - Wait for `downstream_ready` = 1, then go to DONE.
- **DONE**
  - `proab_sum_done` = 1 for exactly one cycle.
  - Return to IDLE.
- **Sum register**
  - `sum` loads `acc` on the HOLD→DONE transition.
  - It then holds until the next frame's DONE, so the previous frame's sum stays valid while the next frame loads.
- **Arithmetic**
  - All adds go through `fp_add`: round-to-nearest-even, denormals flushed to zero, NaN/Inf propagated per IEEE.
  - Accumulation is strictly serial, in stream order.
- **Reset**
  - Valid in any state, including mid-frame.
  - Next cycle: state IDLE; `acc`, `cnt` and `sum` are 0; in-flight `fp_add` results are discarded.
  - Intermediate-memory contents are undefined after reset.

## Timing
- Reset values:
  - `proab_sum_ready` = `downstream_ready` (combinational from IDLE);
  - `in_ready`, `wr_ena`, `proab_sum_done` = 0;
  - `wr_addr`, `wr_data`, `sum` = 0.
- Write port is registered: `wr_ena` is high in the cycle after acceptance, with `wr_addr = cnt` and `wr_data` = accepted element. `wr_ena` is low in all other cycles.
- Element period is at most one accept every ADD_DELAY+1 cycles.
- With `in_valid` held high and `downstream_ready` high:
  - start in cycle 0, first accept in cycle 1;
  - `proab_sum_done` in cycle 1 + DATA_SIZE·(ADD_DELAY+1) + 1.
- The last memory write always completes before `proab_sum_done`.
- `sum` is valid in the `proab_sum_done` cycle and remains stable afterwards.
- Start accepted and `downstream_ready` low in the same cycle: not possible, because the start is rejected.
- `downstream_ready` may fall during LOAD/WAIT_ADD without effect; it is sampled only in IDLE and HOLD.

## Structure
- Shared package `proab_pkg`:
  - state enum;
  - FP constants `FP_ZERO` = 32'h00000000 and `FP_ONE` = 32'h3F800000.
- One sub-module, `fp_add`:
  - ports: `clk`, `rst`, `a`, `b`, `in_vld`, `res`, `out_vld`;
  - fixed latency ADD_DELAY; vendor IP wrapper in synthesis, behavioural model in simulation.
- The FSM, counter and write-port registers live in the top module.

## Test plan
- Frame of 128 × 32'h3F800000, `in_valid` always high, `downstream_ready` high:
  - addresses 0..127 each written once with 3F800000;
  - `sum` = 32'h43000000;
  - single `proab_sum_done` pulse at cycle 1+128·8+1 = 1026 after start.
- Same frame with `downstream_ready` forced low from element 120 for 50 cycles past the last add:
  - `proab_sum_done` fires the cycle after `downstream_ready` rises;
  - `sum` = 43000000 and held.
- `in_valid` randomly deasserted (50%):
  - identical memory contents and `sum`;
  - `wr_addr` strictly sequential, no duplicate or missing writes.
- Start ignored in each of these cases, with no state change and no extra writes:
  - `proab_sum_start` during LOAD;
  - `proab_sum_start` in IDLE with `downstream_ready` = 0.
- `rst` asserted after element 40:
  - next cycle all outputs 0 and state IDLE;
  - a new frame of 128 × 32'h3F000000 gives `sum` = 32'h42800000.
- Back-to-back frames, ones then 32'h40000000:
  - `sum` stays 43000000 throughout the second load;
  - `sum` becomes 32'h43800000 at the second `proab_sum_done`.
